// File: rtl/scan_sync_timestamper.sv
// scan_sync_timestamper: conditions raw scan-start/groove inputs, timestamps their edges
// on a free-running timer and tracks per-direction average scan durations.
module scan_sync_timestamper #(
  parameter int FILT_LEN  = 4,
  parameter int AVG_SHIFT = 3,
  parameter int MIN_SCAN  = 1000,
  parameter int TIMEOUT   = 16777216
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sync_in,
  input  logic        sig_in,
  output logic        sync_start,
  output logic        sig_valid,
  output logic [31:0] sig_time,
  output logic        dir,
  output logic [31:0] afll_ltr,
  output logic [31:0] afll_rtl,
  output logic        locked
);
  typedef enum logic [1:0] {IDLE, FIRST, SEED, TRACK} state_t;
  state_t state, state_nx;
  logic [1:0] meta, sync2, filt, filt_q, rise;
  logic [4:0] cnt [2];
  logic [31:0] timer, last_sync, elapsed, avg_sel, upd;
  logic signed [32:0] diff, step;
  logic accept, tmo;
  // bit 0 carries sync, bit 1 carries sig; both share one conditioning chain
  always_ff @(posedge clk)
    if (!reset_n) begin
      meta   <= '0;
      sync2  <= '0;
      filt   <= '0;
      filt_q <= '0;
      cnt    <= '{default: '0};
    end else begin
      meta   <= {sig_in, sync_in};
      sync2  <= meta;
      filt_q <= filt;
      for (int k = 0; k < 2; k++)
        if (sync2[k] == filt[k]) cnt[k] <= '0;
        else if (cnt[k] == 5'(FILT_LEN - 1)) begin
          filt[k] <= sync2[k];
          cnt[k]  <= '0;
        end else cnt[k] <= cnt[k] + 5'd1;
    end
  always_comb begin
    rise     = filt & ~filt_q;
    elapsed  = timer - last_sync;
    accept   = rise[0] && (state == IDLE || elapsed >= 32'(MIN_SCAN));
    tmo      = state != IDLE && elapsed >= 32'(TIMEOUT) && !accept;
    avg_sel  = dir ? afll_rtl : afll_ltr;
    diff     = $signed({1'b0, elapsed}) - $signed({1'b0, avg_sel});
    step     = diff >>> AVG_SHIFT;
    upd      = avg_sel + 32'(step);
    state_nx = tmo ? IDLE : !accept ? state : state == IDLE ? FIRST : state == FIRST ? SEED : TRACK;
  end
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (!reset_n) begin
      timer      <= '0;
      last_sync  <= '0;
      sync_start <= 1'b0;
      sig_valid  <= 1'b0;
      sig_time   <= '0;
      dir        <= 1'b0;
      afll_ltr   <= '0;
      afll_rtl   <= '0;
      locked     <= 1'b0;
    end else begin
      timer      <= timer + 32'd1;
      sync_start <= accept;
      sig_valid  <= rise[1];
      if (rise[1]) sig_time <= timer;
      if (accept) last_sync <= timer;
      if (tmo) begin
        afll_ltr <= '0;
        afll_rtl <= '0;
        dir      <= 1'b0;
        locked   <= 1'b0;
      end else if (accept)
        case (state)
          IDLE:  dir <= 1'b0;
          FIRST: begin
            afll_ltr <= elapsed;
            dir      <= 1'b1;
          end
          SEED: begin
            afll_rtl <= elapsed;
            dir      <= 1'b0;
            locked   <= 1'b1;
          end
          default: begin
            if (dir) afll_rtl <= upd;
            else afll_ltr <= upd;
            dir <= ~dir;
          end
        endcase
    end
endmodule

// File: tb/tb_scan_sync_timestamper.sv
// tb_scan_sync_timestamper: directed table, corner sequences and randomized syncs
// checked against an event-level model of the scan tracker.
module tb_scan_sync_timestamper;
  localparam int TMO = 12000;
  localparam int MIN = 1000;
  localparam int SH  = 3;
  logic clk = 1'b0, reset_n = 1'b0, sync_in = 1'b0, sig_in = 1'b0;
  logic sync_start, sig_valid, dir, locked;
  logic [31:0] sig_time, afll_ltr, afll_rtl;
  int cyc = 0, n_cmp = 0, n_bad = 0, n_start = 0, n_sig = 0;
  int m_st = 0, m_last = 0;
  bit m_dir = 1'b0, m_lk = 1'b0;
  logic [31:0] m_ltr = '0, m_rtl = '0;

  scan_sync_timestamper #(.FILT_LEN(4), .AVG_SHIFT(SH), .MIN_SCAN(MIN), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .sync_in(sync_in), .sig_in(sig_in),
    .sync_start(sync_start), .sig_valid(sig_valid), .sig_time(sig_time),
    .dir(dir), .afll_ltr(afll_ltr), .afll_rtl(afll_rtl), .locked(locked));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sync_start) n_start++;
    if (sig_valid) n_sig++;
  end

  typedef struct {
    int gap;
    int w;
    int starts;
    logic d;
    logic [31:0] l;
    logic [31:0] r;
    logic lk;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic d, input logic [31:0] l, input logic [31:0] r, input logic lk);
    chk({name, "_dir"}, 32'(dir), 32'(d));
    chk({name, "_ltr"}, afll_ltr, l);
    chk({name, "_rtl"}, afll_rtl, r);
    chk({name, "_locked"}, 32'(locked), 32'(lk));
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drive(input int t, input int w, input bit with_sig);
    wait_to(t);
    sync_in = 1'b1;
    sig_in  = with_sig;
    wait_to(t + w);
    sync_in = 1'b0;
    sig_in  = 1'b0;
  endtask

  task automatic sig_pulse(input int t);
    wait_to(t);
    sig_in = 1'b1;
    wait_to(t + 6);
    sig_in = 1'b0;
  endtask

  function automatic logic [31:0] ewma(input logic [31:0] avg, input int meas);
    longint d;
    d = longint'(meas) - longint'(avg);
    return 32'(longint'(avg) + (d >>> SH));
  endfunction

  function automatic void model_reset();
    m_st = 0; m_dir = 1'b0; m_lk = 1'b0; m_ltr = '0; m_rtl = '0;
  endfunction

  // rises are judged by their driven cycle; conditioning latency is common to all
  function automatic bit model_sync(input int t);
    int meas;
    meas = t - m_last;
    if (m_st != 0 && meas < MIN) return 1'b0;
    case (m_st)
      1: begin m_ltr = 32'(meas); m_dir = 1'b1; end
      2: begin m_rtl = 32'(meas); m_dir = 1'b0; m_lk = 1'b1; end
      3: begin
        if (m_dir) m_rtl = ewma(m_rtl, meas);
        else m_ltr = ewma(m_ltr, meas);
        m_dir = !m_dir;
      end
      default: m_dir = 1'b0;
    endcase
    m_st = (m_st == 3) ? 3 : m_st + 1;
    m_last = t;
    return 1'b1;
  endfunction

  initial begin
    int t, ta, s0, g0;
    logic [31:0] st0, w0, w1, prev_val;
    int prev_t;
    bit quiet_bad, acc, has_sig;
    int gap, off;
    tbl[0] = '{100,  10, 1, 1'b0, 32'd0,    32'd0,    1'b0};
    tbl[1] = '{5000, 10, 1, 1'b1, 32'd5000, 32'd0,    1'b0};
    tbl[2] = '{5000, 10, 1, 1'b0, 32'd5000, 32'd5000, 1'b1};
    tbl[3] = '{5080, 10, 1, 1'b1, 32'd5010, 32'd5000, 1'b1};
    tbl[4] = '{300,  2,  0, 1'b1, 32'd5010, 32'd5000, 1'b1};
    tbl[5] = '{200,  10, 0, 1'b1, 32'd5010, 32'd5000, 1'b1};
    tbl[6] = '{4500, 10, 1, 1'b0, 32'd5010, 32'd5000, 1'b1};
    // inputs held high during reset must not leak through
    sync_in = 1'b1;
    sig_in  = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_flags", 32'({sync_start, sig_valid, dir, locked}), 32'd0);
    chk("rst_sig_time", sig_time, 32'd0);
    chk("rst_ltr", afll_ltr, 32'd0);
    chk("rst_rtl", afll_rtl, 32'd0);
    sync_in = 1'b0;
    sig_in  = 1'b0;
    reset_n = 1'b1;
    quiet_bad = 1'b0;
    t = cyc;
    repeat (100) begin
      @(negedge clk);
      if (|{sync_start, sig_valid, sig_time, dir, afll_ltr, afll_rtl, locked}) quiet_bad = 1'b1;
    end
    chk("quiet_outputs", 32'(quiet_bad), 32'd0);
    for (int i = 0; i < 7; i++) begin
      t += tbl[i].gap;
      s0 = n_start;
      drive(t, tbl[i].w, 1'b0);
      wait_to(t + 30);
      chk($sformatf("tbl%0d_starts", i), 32'(n_start - s0), 32'(tbl[i].starts));
      chk_state($sformatf("tbl%0d", i), tbl[i].d, tbl[i].l, tbl[i].r, tbl[i].lk);
    end
    // sync and sig rising together, then a sig rise 1234 cycles into the scan
    t += 5000;
    g0 = n_sig;
    drive(t, 10, 1'b1);
    wait_to(t + 30);
    st0 = sig_time;
    chk("simul_sig_count", 32'(n_sig - g0), 32'd1);
    chk_state("simul", 1'b1, 32'd5008, 32'd5000, 1'b1);
    sig_pulse(t + 1234);
    wait_to(t + 1234 + 30);
    chk("sig_offset", sig_time - st0, 32'd1234);
    chk("sig_count", 32'(n_sig - g0), 32'd2);
    ta = t;
    s0 = n_start;
    wait_to(ta + TMO - 50);
    chk("pre_timeout_locked", 32'(locked), 32'd1);
    wait_to(ta + TMO + 40);
    chk_state("timeout", 1'b0, 32'd0, 32'd0, 1'b0);
    chk("timeout_starts", 32'(n_start - s0), 32'd0);
    // re-seed across the timer wrap, starting from IDLE
    @(negedge clk);
    force dut.timer = 32'hFFFF_F000;
    @(negedge clk);
    release dut.timer;
    model_reset();
    t = cyc + 100;
    drive(t, 10, 1'b1);
    acc = model_sync(t);
    wait_to(t + 30);
    w0 = sig_time;
    chk_state("wrap0", 1'b0, 32'd0, 32'd0, 1'b0);
    t += 5000;
    drive(t, 10, 1'b1);
    acc = model_sync(t);
    wait_to(t + 30);
    w1 = sig_time;
    chk("wrap_sig_diff", w1 - w0, 32'd5000);
    chk("wrap_happened", 32'(w1 < w0), 32'd1);
    chk_state("wrap1", 1'b1, 32'd5000, 32'd0, 1'b0);
    t += 5000;
    drive(t, 10, 1'b0);
    acc = model_sync(t);
    wait_to(t + 30);
    chk_state("wrap2", 1'b0, 32'd5000, 32'd5000, 1'b1);
    prev_t = -1;
    prev_val = '0;
    for (int i = 0; i < 25; i++) begin
      gap = ($urandom_range(0, 4) == 0) ? int'($urandom_range(500, 999)) : int'($urandom_range(1000, 2200));
      t += gap;
      s0 = n_start;
      g0 = n_sig;
      acc = model_sync(t);
      has_sig = 1'($urandom_range(0, 1));
      off = int'($urandom_range(20, 300));
      drive(t, 10, 1'b0);
      if (has_sig) sig_pulse(t + off);
      wait_to(t + 450);
      chk($sformatf("rnd%0d_starts", i), 32'(n_start - s0), 32'(acc));
      chk_state($sformatf("rnd%0d", i), m_dir, m_ltr, m_rtl, m_lk);
      if (has_sig) begin
        chk($sformatf("rnd%0d_sig_count", i), 32'(n_sig - g0), 32'd1);
        if (prev_t >= 0) chk($sformatf("rnd%0d_sig_delta", i), sig_time - prev_val, 32'(t + off - prev_t));
        prev_t = t + off;
        prev_val = sig_time;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/scan_sync_timestamper.md
Name: scan_sync_timestamper

Overview:
- Upstream front end of the groove sampler. Conditions the raw scan-start and groove-detector comparator inputs and timestamps their edges on a free-running 32-bit timer.
- Tracks scan direction and keeps per-direction average scan durations.
- Outputs sync_start, sig_time, dir, afll_ltr and afll_rtl, which feed the sample-timestamp stage directly.

Parameters:
- FILT_LEN, 4: consecutive equal samples required before a filtered input changes state (1..16).
- AVG_SHIFT, 3: exponential-average weight; avg += (meas - avg) >>> AVG_SHIFT.
- MIN_SCAN, 1000: minimum cycles between accepted syncs. Syncs arriving earlier are ignored.
- TIMEOUT, 16777216: cycles without an accepted sync before lock is dropped.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- sync_in  in  1  raw scan-start pulse, asynchronous
- sig_in  in  1  raw groove comparator, asynchronous
- sync_start  out  1  one-cycle pulse per accepted scan start
- sig_valid  out  1  one-cycle pulse per accepted sig rising edge
- sig_time  out  32  timer value at last accepted sig rising edge; held between edges
- dir  out  1  direction of current scan: 0 = LTR, 1 = RTL
- afll_ltr  out  32  average LTR scan duration in cycles; 0 = unknown
- afll_rtl  out  32  average RTL scan duration in cycles; 0 = unknown
- locked  out  1  both averages seeded and no timeout since

Behaviour:
- Reset is clk, reset_n, synchronous, active-low. While it is held:
  - all outputs are 0, timer = 0, state = IDLE;
  - filters and synchronizers are cleared to 0.
- Reset mid-scan discards all measurements.
- Timer: free-running 32-bit counter, +1 per cycle, wraps modulo 2^32.
  - All durations are computed as unsigned modulo-2^32 differences, so they are correct across wrap.
- Input conditioning is identical for both inputs, so relative timing is preserved:
  - 2-FF synchronizer, then a FILT_LEN glitch filter.
  - The filter output toggles only after FILT_LEN consecutive synchronizer samples differ from it.
  - Rising edge = filter output 0→1. Both inputs share the same fixed latency.
- Sig path:
  - On a filtered sig rise: sig_time <= timer in that cycle, and sig_valid = 1 for exactly one cycle.
  - Sig edges are timestamped in every state, including IDLE.
- Sync acceptance:
  - A filtered sync rise is accepted if state = IDLE, or if (timer - last_sync) >= MIN_SCAN.
  - Otherwise it is ignored: no pulse, no state change.
- On an accepted sync:
  - meas = timer - last_sync;
  - last_sync <= timer;
  - sync_start = 1 for one cycle;
  - the timeout counter is cleared.
- States:
  - IDLE: dir = 0, averages are 0.
    - First accepted sync → FIRST, with dir = 0. No measurement is taken.
  - FIRST: next accepted sync ends the LTR scan.
    - afll_ltr <= meas (seed), dir <= 1 → SEED.
  - SEED: next accepted sync ends the RTL scan.
    - afll_rtl <= meas (seed), dir <= 0, locked <= 1 → TRACK.
  - TRACK: each accepted sync updates the average of the direction just ended:
    - avg <= avg + ((meas - avg) >>> AVG_SHIFT), signed 33-bit intermediate, result truncated to 32 bits;
    - then dir toggles.
- Timeout:
  - In any state other than IDLE, if (timer - last_sync) reaches TIMEOUT with no accepted sync, on the next cycle:
    - state → IDLE;
    - afll_ltr = afll_rtl = 0, dir = 0, locked = 0;
    - sync_start stays 0.
  - Zero averages force the downstream stage to emit silence.
- Output timing: dir and the averages update in the same cycle sync_start is asserted. Downstream sees the new dir on the cycle after the pulse.
- Simultaneous sync and sig rise in the same cycle:
  - both are processed;
  - sig_time = the timer value, equal to the new last_sync (position 0 of the new scan).
- Accepted sync coinciding with the timeout cycle: the sync wins, and the timeout is not taken.

Test Plan:
- Reset, then hold sync_in/sig_in at 0 for 100 cycles → all outputs stay 0. Timer reaches 100.
- sync_in 10-cycle pulses every 5000 cycles, FILT_LEN = 4:
  - 1st sync → FIRST, dir = 0;
  - 2nd → afll_ltr = 5000, dir = 1;
  - 3rd → afll_rtl = 5000, locked = 1, dir = 0;
  - a 4th at +5080 → afll_ltr = 5010.
- 2-cycle glitch on sync_in, and a sync rise 500 cycles after the last accepted one → no sync_start, no state change.
- Sig rise 1234 cycles after an accepted sync → sig_valid pulses once, sig_time - last_sync = 1234.
- Preload the timer near 0xFFFFFF00 (bench force) and run syncs 5000 apart across the wrap → measured duration = 5000, averages unchanged.
- While locked, stop sync_in for TIMEOUT + 10 cycles → locked = 0, afll_ltr = afll_rtl = 0, dir = 0. The next two syncs re-seed.
